gmii_rx_frame: RTL and testbench
================================

Name: gmii_rx_frame

Overview:
Receive-side framing stage for the KSZ9031 GMII port. It sits directly downstream of the PHY RX pins and is the receive-path counterpart of the TX MAC. It strips preamble, SFD, Ethernet header and FCS, and filters on destination MAC. It checks CRC-32, length and PHY error, then streams payload bytes to the host-command/control logic with SOF/EOF/error framing.

Parameters:
LOCAL_MAC, 48'h020000000001, unicast address accepted besides broadcast
MIN_FRAME, 64, minimum legal frame length in bytes (dest MAC through FCS)
MAX_FRAME, 1518, maximum legal frame length in bytes (dest MAC through FCS)

Ports:
clk  in  1  125 MHz GMII RX clock domain
rst_n  in  1  asynchronous, active-low reset
gmii_rx_d  in  8  GMII receive data
gmii_rx_dv  in  1  GMII receive data valid
gmii_rx_er  in  1  GMII receive error
promisc  in  1  1 = accept any destination MAC
m_data  out  8  payload byte
m_valid  out  1  payload byte valid; no backpressure
m_sof  out  1  first payload byte of frame (qualified by m_valid)
m_eof  out  1  last payload byte of frame (qualified by m_valid)
m_err  out  1  frame bad; meaningful only with m_valid & m_eof
rx_src_mac  out  48  source MAC of last accepted frame
rx_ethertype  out  16  EtherType of last accepted frame
frames_ok  out  32  good frames delivered
frames_bad  out  32  delivered frames ending with m_err=1
frames_filtered  out  32  frames dropped by address filter or malformed preamble

Behaviour:
- Reset: all outputs 0. State IDLE, delay line empty, CRC = 32'hFFFFFFFF. Reset takes effect asynchronously mid-frame; the partial frame is discarded with no m_eof.
- Inputs are sampled on posedge clk. All m_* outputs are registered.
- States: IDLE, PREAMBLE, HDR, PAYLOAD, DROP.
- IDLE:
  - dv & d==8'h55 -> PREAMBLE.
  - dv & any other byte -> DROP, frames_filtered++.
- PREAMBLE:
  - dv & 8'h55 -> stay; any count of preamble bytes is accepted.
  - dv & 8'hD5 -> HDR. Byte count = 0, CRC = all-ones.
  - dv & other byte -> DROP, frames_filtered++.
  - !dv -> IDLE, nothing counted.
- HDR, bytes 0..13:
  - Bytes 0-5: destination MAC, compared against LOCAL_MAC or FF:FF:FF:FF:FF:FF.
  - Bytes 6-11: source MAC, shifted into a holding register.
  - Bytes 12-13: EtherType.
  - At byte 13: if address matches or promisc=1 -> PAYLOAD, and rx_src_mac/rx_ethertype update. Otherwise -> DROP, frames_filtered++.
  - !dv inside HDR -> IDLE, counts as frames_filtered++.
- CRC-32: reflected polynomial 32'hEDB88320, LSB-first, init all-ones. Updated once per byte from header byte 0 through the last FCS byte. Frame is CRC-good iff the register equals 32'hDEBB20E3 after the final byte.
- Byte count: 16-bit, saturating; counts header byte 0 through the FCS.
- PAYLOAD uses a 5-entry byte delay line.
  - Each received byte is pushed.
  - When the line is full and a new byte arrives, the oldest byte is emitted: m_valid=1, m_eof=0.
  - m_sof=1 on the first emitted byte of the frame.
  - Latency: payload byte k appears on m_data the cycle after payload byte k+5 is sampled.
- End of frame: first cycle with dv=0 in PAYLOAD.
  - If the line holds 5 bytes, emit the oldest with m_eof=1. The remaining 4 bytes are the FCS and are discarded.
  - m_err = CRC bad | count<MIN_FRAME | count>MAX_FRAME | any gmii_rx_er seen since SFD.
  - m_err=0 -> frames_ok++; m_err=1 -> frames_bad++.
  - If the line holds fewer than 5 bytes, nothing is emitted, no m_sof was issued, and frames_bad++.
  - In the same cycle: return to IDLE, clear the line and error flags.
- m_sof and m_eof both 1: only possible with exactly 1 payload byte. This is legal; m_err is then set by the runt check.
- gmii_rx_er during PAYLOAD: latch the error flag and continue streaming.
- Oversize: streaming continues; the error is flagged only at EOF.
- DROP: ignore data until dv=0, then -> IDLE.
- Back-to-back frames: a single dv=0 cycle between frames suffices. The new frame's preamble may start on the very next cycle.
- No backpressure exists: the consumer must accept one byte per cycle.
- All counters are 32-bit and wrap.

Test Plan:
- Broadcast frame: 7x55, D5, 14-byte header, 46 payload bytes 0x00..0x2D, correct FCS (64 bytes) -> 46 m_valid beats, m_sof on 0x00, m_eof on 0x2D with m_err=0, frames_ok=1, rx_ethertype=16'h0800.
- Same frame with payload byte 10 flipped -> 46 beats delivered, m_eof with m_err=1, frames_bad=1, frames_ok unchanged.
- Destination 02:00:00:00:00:02 with promisc=0 -> no m_valid, frames_filtered=1. Repeat with promisc=1 -> delivered, frames_ok=1.
- Runt: 60-byte frame with valid CRC -> 42 beats, m_eof with m_err=1, frames_bad=1.
- gmii_rx_er pulsed at payload byte 20 of a good 100-byte frame -> all 82 payload beats delivered, m_err=1 on m_eof.
- rst_n asserted mid-payload, then a good frame sent -> outputs 0 during reset, no m_eof for the aborted frame, second frame delivered cleanly with frames_ok=1. Two good frames separated by a 1-cycle dv gap -> frames_ok=2.

Source files
------------

// File: rtl/gmii_rx_frame.sv
// GMII receive framing: strips preamble/SFD/header/FCS, filters on destination
// MAC, checks CRC-32, length and PHY error, and streams payload bytes with
// SOF/EOF/error framing. One byte per cycle, no backpressure.
module gmii_rx_frame #(
  parameter logic [47:0] LOCAL_MAC = 48'h020000000001,
  parameter int          MIN_FRAME = 64,
  parameter int          MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rx_d,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic        promisc,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  output logic        m_err,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_ethertype,
  output logic [31:0] frames_ok,
  output logic [31:0] frames_bad,
  output logic [31:0] frames_filtered
);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HDR, S_PAYLOAD, S_DROP} state_e;

  // Delay line depth equals FCS length + 1 so the FCS never leaves the block.
  localparam int          DLY      = 5;
  localparam logic [2:0]  DLY_FULL = 3'(DLY);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_FRAME);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;
  // Byte 0 of the destination is the MSB of the address.
  localparam logic [5:0][7:0] MAC_B = LOCAL_MAC;

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [31:0]          crc_q, crc_d;
  logic [DLY-1:0][7:0]  dl_q, dl_d;
  logic [2:0]           dl_n_q, dl_n_d;
  logic                 er_q, er_d;
  logic                 ucast_q, ucast_d;
  logic                 bcast_q, bcast_d;
  logic                 sof_pend_q, sof_pend_d;
  logic [47:0]          src_q, src_d;
  logic [7:0]           eth_hi_q, eth_hi_d;

  logic [7:0]           m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_sof_q, m_sof_d;
  logic                 m_eof_q, m_eof_d;
  logic                 m_err_q, m_err_d;
  logic [47:0]          rx_src_q, rx_src_d;
  logic [15:0]          rx_eth_q, rx_eth_d;
  logic [31:0]          ok_q, ok_d;
  logic [31:0]          bad_q, bad_d;
  logic [31:0]          filt_q, filt_d;

  logic [15:0]          cnt_inc;
  logic [31:0]          crc_nxt;
  logic [2:0]           mac_sel;
  logic                 frame_bad;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign crc_nxt   = crc_byte(crc_q, gmii_rx_d);
  assign mac_sel   = 3'd5 - cnt_q[2:0];
  assign frame_bad = (crc_q != CRC_RES) | (cnt_q < MIN_CNT) | (cnt_q > MAX_CNT) | er_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    dl_d       = dl_q;
    dl_n_d     = dl_n_q;
    er_d       = er_q;
    ucast_d    = ucast_q;
    bcast_d    = bcast_q;
    sof_pend_d = sof_pend_q;
    src_d      = src_q;
    eth_hi_d   = eth_hi_q;
    m_data_d   = m_data_q;
    m_valid_d  = 1'b0;
    m_sof_d    = 1'b0;
    m_eof_d    = 1'b0;
    m_err_d    = 1'b0;
    rx_src_d   = rx_src_q;
    rx_eth_d   = rx_eth_q;
    ok_d       = ok_q;
    bad_d      = bad_q;
    filt_d     = filt_q;

    unique case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rx_d == 8'h55) begin
            state_d = S_PREAMBLE;
          end else begin
            state_d = S_DROP;
            filt_d  = filt_q + 32'd1;
          end
        end
      end

      S_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
        end else if (gmii_rx_d == 8'hD5) begin
          state_d = S_HDR;
          cnt_d   = 16'd0;
          crc_d   = CRC_INIT;
          er_d    = 1'b0;
          ucast_d = 1'b1;
          bcast_d = 1'b1;
        end else if (gmii_rx_d != 8'h55) begin
          state_d = S_DROP;
          filt_d  = filt_q + 32'd1;
        end
      end

      S_HDR: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
          filt_d  = filt_q + 32'd1;
        end else begin
          cnt_d = cnt_inc;
          crc_d = crc_nxt;
          if (gmii_rx_er) er_d = 1'b1;
          if (cnt_q < 16'd6) begin
            ucast_d = ucast_q & (gmii_rx_d == MAC_B[mac_sel]);
            bcast_d = bcast_q & (gmii_rx_d == 8'hFF);
          end else if (cnt_q < 16'd12) begin
            src_d = {src_q[39:0], gmii_rx_d};
          end else if (cnt_q == 16'd12) begin
            eth_hi_d = gmii_rx_d;
          end else if (ucast_q | bcast_q | promisc) begin
            state_d    = S_PAYLOAD;
            rx_src_d   = src_q;
            rx_eth_d   = {eth_hi_q, gmii_rx_d};
            sof_pend_d = 1'b1;
            dl_n_d     = 3'd0;
          end else begin
            state_d = S_DROP;
            filt_d  = filt_q + 32'd1;
          end
        end
      end

      S_PAYLOAD: begin
        if (gmii_rx_dv) begin
          cnt_d = cnt_inc;
          crc_d = crc_nxt;
          if (gmii_rx_er) er_d = 1'b1;
          dl_d = {dl_q[DLY-2:0], gmii_rx_d};
          if (dl_n_q == DLY_FULL) begin
            m_valid_d  = 1'b1;
            m_data_d   = dl_q[DLY-1];
            m_sof_d    = sof_pend_q;
            sof_pend_d = 1'b0;
          end else begin
            dl_n_d = dl_n_q + 3'd1;
          end
        end else begin
          // End of frame: the four youngest bytes in the line are the FCS.
          if (dl_n_q == DLY_FULL) begin
            m_valid_d = 1'b1;
            m_data_d  = dl_q[DLY-1];
            m_sof_d   = sof_pend_q;
            m_eof_d   = 1'b1;
            m_err_d   = frame_bad;
            if (frame_bad) bad_d = bad_q + 32'd1;
            else           ok_d  = ok_q + 32'd1;
          end else begin
            bad_d = bad_q + 32'd1;
          end
          state_d    = S_IDLE;
          dl_n_d     = 3'd0;
          er_d       = 1'b0;
          sof_pend_d = 1'b0;
        end
      end

      S_DROP: begin
        if (!gmii_rx_dv) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      dl_q       <= '0;
      dl_n_q     <= '0;
      er_q       <= 1'b0;
      ucast_q    <= 1'b0;
      bcast_q    <= 1'b0;
      sof_pend_q <= 1'b0;
      src_q      <= '0;
      eth_hi_q   <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eof_q    <= 1'b0;
      m_err_q    <= 1'b0;
      rx_src_q   <= '0;
      rx_eth_q   <= '0;
      ok_q       <= '0;
      bad_q      <= '0;
      filt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      dl_q       <= dl_d;
      dl_n_q     <= dl_n_d;
      er_q       <= er_d;
      ucast_q    <= ucast_d;
      bcast_q    <= bcast_d;
      sof_pend_q <= sof_pend_d;
      src_q      <= src_d;
      eth_hi_q   <= eth_hi_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_sof_q    <= m_sof_d;
      m_eof_q    <= m_eof_d;
      m_err_q    <= m_err_d;
      rx_src_q   <= rx_src_d;
      rx_eth_q   <= rx_eth_d;
      ok_q       <= ok_d;
      bad_q      <= bad_d;
      filt_q     <= filt_d;
    end
  end

  assign m_data          = m_data_q;
  assign m_valid         = m_valid_q;
  assign m_sof           = m_sof_q;
  assign m_eof           = m_eof_q;
  assign m_err           = m_err_q;
  assign rx_src_mac      = rx_src_q;
  assign rx_ethertype    = rx_eth_q;
  assign frames_ok       = ok_q;
  assign frames_bad      = bad_q;
  assign frames_filtered = filt_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Scoreboard bench for gmii_rx_frame: the frame sender pushes the expected
// payload beats, an independent negedge monitor pops and compares them.
module tb_gmii_rx_frame;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gmii_rx_d = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic        promisc = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_sof, m_eof, m_err;
  logic [47:0] rx_src_mac;
  logic [15:0] rx_ethertype;
  logic [31:0] frames_ok, frames_bad, frames_filtered;

  gmii_rx_frame dut (
    .clk(clk), .rst_n(rst_n),
    .gmii_rx_d(gmii_rx_d), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .promisc(promisc),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eof(m_eof), .m_err(m_err),
    .rx_src_mac(rx_src_mac), .rx_ethertype(rx_ethertype),
    .frames_ok(frames_ok), .frames_bad(frames_bad), .frames_filtered(frames_filtered)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
  } beat_t;

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] LOCAL = 48'h0200_0000_0001;
  localparam logic [47:0] OTHER = 48'h0200_0000_0002;
  localparam logic [47:0] SRC1  = 48'h0011_2233_4455;
  localparam logic [47:0] SRC2  = 48'hA0B0_C0D0_E0F0;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    ignore = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial Ethernet FCS over the given bytes (already complemented).
  function automatic logic [31:0] calc_fcs(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    gmii_rx_d  = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  // Build and send one frame; payload byte i = i. flip_idx/er_idx < 0 disable
  // corruption / PHY error; abort_at >= 0 stops mid-frame at that frame byte.
  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input int plen,
                            input int flip_idx, input int er_idx, input bit deliver,
                            input bit exp_err, input int abort_at);
    logic [7:0]  f[$];
    logic [31:0] c;
    beat_t       b;
    for (int i = 0; i < 6; i++) f.push_back(dst[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) f.push_back(src[8*(5-i) +: 8]);
    f.push_back(8'h08);
    f.push_back(8'h00);
    for (int i = 0; i < plen; i++) f.push_back(8'(i));
    c = calc_fcs(f);
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    if (flip_idx >= 0) f[14+flip_idx] = ~f[14+flip_idx];
    if (deliver) begin
      for (int i = 0; i < plen; i++) begin
        b.d   = f[14+i];
        b.sof = (i == 0);
        b.eof = (i == plen - 1);
        b.err = exp_err;
        exp_q.push_back(b);
      end
    end
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    foreach (f[i]) begin
      if (i == abort_at) return;
      drive(f[i], 1'b1, (er_idx >= 0) && (i == 14 + er_idx));
    end
    drive(8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: every delivered byte must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    beat_t e;
    if (rst_n && m_valid) begin
      if (ignore) begin
        chk("abort_no_eof", 64'(m_eof), 64'd0);
      end else if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h, expected no beat", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 64'(m_data), 64'(e.d));
        chk("beat_sof", 64'(m_sof), 64'(e.sof));
        chk("beat_eof", 64'(m_eof), 64'(e.eof));
        if (e.eof) chk("beat_err", 64'(m_err), 64'(e.err));
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_strobes"}, 64'({m_valid, m_sof, m_eof, m_err}), 64'd0);
    chk({name, "_data"}, 64'(m_data), 64'd0);
    chk({name, "_src"}, 64'(rx_src_mac), 64'd0);
    chk({name, "_type"}, 64'(rx_ethertype), 64'd0);
    chk({name, "_cnts"}, 64'(frames_ok | frames_bad | frames_filtered), 64'd0);
  endtask

  task automatic chk_cnt(input string name, input int ok, input int bad, input int filt);
    chk({name, "_ok"}, 64'(frames_ok), 64'(ok));
    chk({name, "_bad"}, 64'(frames_bad), 64'(bad));
    chk({name, "_filt"}, 64'(frames_filtered), 64'(filt));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // 64-byte broadcast frame, 46 payload bytes
    send_frame(BCAST, SRC1, 46, -1, -1, 1'b1, 1'b0, -1);
    idle(4);
    chk_cnt("bcast", 1, 0, 0);
    chk("bcast_type", 64'(rx_ethertype), 64'h0800);
    chk("bcast_src", 64'(rx_src_mac), 64'(SRC1));

    // same frame, payload byte 10 corrupted after FCS computed
    send_frame(BCAST, SRC1, 46, 10, -1, 1'b1, 1'b1, -1);
    idle(4);
    chk_cnt("crcbad", 1, 1, 0);

    // foreign unicast dropped, source register keeps last accepted frame
    send_frame(OTHER, SRC2, 46, -1, -1, 1'b0, 1'b0, -1);
    idle(4);
    chk_cnt("filter", 1, 1, 1);
    chk("filter_src", 64'(rx_src_mac), 64'(SRC1));

    // same destination accepted in promiscuous mode
    promisc = 1'b1;
    send_frame(OTHER, SRC2, 46, -1, -1, 1'b1, 1'b0, -1);
    idle(4);
    promisc = 1'b0;
    chk_cnt("promisc", 2, 1, 1);
    chk("promisc_src", 64'(rx_src_mac), 64'(SRC2));

    // own unicast address
    send_frame(LOCAL, SRC1, 50, -1, -1, 1'b1, 1'b0, -1);
    idle(4);
    chk_cnt("ucast", 3, 1, 1);

    // 60-byte runt with valid CRC
    send_frame(BCAST, SRC1, 42, -1, -1, 1'b1, 1'b1, -1);
    idle(4);
    chk_cnt("runt", 3, 2, 1);

    // single payload byte: SOF and EOF together, runt error
    send_frame(BCAST, SRC1, 1, -1, -1, 1'b1, 1'b1, -1);
    idle(4);
    chk_cnt("onebyte", 3, 3, 1);

    // PHY error on payload byte 20 of a 100-byte frame
    send_frame(BCAST, SRC1, 82, -1, 20, 1'b1, 1'b1, -1);
    idle(4);
    chk_cnt("phyer", 3, 4, 1);

    // malformed start (no preamble)
    drive(8'h12, 1'b1, 1'b0);
    drive(8'h34, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    idle(3);
    chk_cnt("badpre", 3, 4, 2);
    chk("drain1", 64'(exp_q.size()), 64'd0);

    // reset mid-payload: 30 payload bytes in
    ignore = 1'b1;
    send_frame(BCAST, SRC1, 46, -1, -1, 1'b0, 1'b0, 14 + 30);
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b0;
    #1;
    chk_all_zero("midrst");
    idle(2);
    chk_all_zero("inrst");
    rst_n  = 1'b1;
    idle(3);
    ignore = 1'b0;

    send_frame(BCAST, SRC2, 46, -1, -1, 1'b1, 1'b0, -1);
    idle(4);
    chk_cnt("postrst", 1, 0, 0);

    // back-to-back frames with a single idle cycle between them
    send_frame(BCAST, SRC1, 46, -1, -1, 1'b1, 1'b0, -1);
    send_frame(LOCAL, SRC2, 47, -1, -1, 1'b1, 1'b0, -1);
    idle(4);
    chk_cnt("b2b", 3, 0, 0);
    chk("drain2", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
